// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth multiplier: retires DPC digits per RUN cycle into a 2*WIDTH accumulator.
// Latency: ceil(D/DPC) cycles from accept to out_valid (D = WIDTH/2 signed, WIDTH/2+1 unsigned).
// Backpressure: the product is held in DONE until out_ready; new operands are accepted only in IDLE.
module booth_r4_seq_mult #(
  parameter int WIDTH = 16,
  parameter int DPC   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p
);

  localparam int PW = 2 * WIDTH;
  localparam int BW = WIDTH + 3;
  localparam int IW = $clog2(WIDTH + DPC + 2) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [PW-1:0]   out_p_q, out_p_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   am_q, am_d;
  logic [BW-1:0]   bsh_q, bsh_d;
  logic [IW-1:0]   i_q, i_d;
  logic            signed_q, signed_d;

  logic            accept;
  logic            last_iter;
  logic [IW-1:0]   d_lim;
  logic [PW-1:0]   acc_sum;
  logic [PW-1:0]   mag;
  logic [2:0]      trip;
  logic            dig_single, dig_double, dig_neg;

  assign accept    = (state_q == S_IDLE) && in_valid && in_ready_q;
  assign d_lim     = signed_q ? IW'(WIDTH / 2) : IW'(WIDTH / 2 + 1);
  assign last_iter = (i_q + IW'(DPC)) >= d_lim;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid && in_ready_q) state_d = S_RUN;
      S_RUN:  if (last_iter) state_d = S_DONE;
      S_DONE: if (out_valid_q && out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: handshake flags are registered versions of the next state
  always_comb begin
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // Digit chain: digit j of this cycle sees multiplicand pre-shifted by 2*(i+j)
  always_comb begin
    acc_sum    = acc_q;
    mag        = '0;
    trip       = '0;
    dig_single = 1'b0;
    dig_double = 1'b0;
    dig_neg    = 1'b0;
    for (int j = 0; j < DPC; j++) begin
      trip       = bsh_q[2*j +: 3];
      dig_single = trip[1] ^ trip[0];
      dig_double = (~trip[2] & trip[1] & trip[0]) | (trip[2] & ~trip[1] & ~trip[0]);
      dig_neg    = trip[2];
      if (dig_single)      mag = am_q << (2 * j);
      else if (dig_double) mag = am_q << (2 * j + 1);
      else                 mag = '0;
      if ((i_q + IW'(j)) < d_lim && (dig_single || dig_double)) begin
        acc_sum = dig_neg ? (acc_sum - mag) : (acc_sum + mag);
      end
    end
  end

  always_comb begin
    acc_d    = acc_q;
    am_d     = am_q;
    bsh_d    = bsh_q;
    i_d      = i_q;
    signed_d = signed_q;
    out_p_d  = out_p_q;
    if (accept) begin
      am_d     = in_signed ? {{WIDTH{in_a[WIDTH-1]}}, in_a} : {{WIDTH{1'b0}}, in_a};
      bsh_d    = in_signed ? {{2{in_b[WIDTH-1]}}, in_b, 1'b0} : {2'b00, in_b, 1'b0};
      acc_d    = '0;
      i_d      = '0;
      signed_d = in_signed;
    end else if (state_q == S_RUN) begin
      acc_d = acc_sum;
      am_d  = am_q << (2 * DPC);
      bsh_d = bsh_q >> (2 * DPC);
      i_d   = i_q + IW'(DPC);
      if (last_iter) out_p_d = acc_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      am_q     <= '0;
      bsh_q    <= '0;
      i_q      <= '0;
      signed_q <= 1'b0;
      out_p_q  <= '0;
    end else begin
      acc_q    <= acc_d;
      am_q     <= am_d;
      bsh_q    <= bsh_d;
      i_q      <= i_d;
      signed_q <= signed_d;
      out_p_q  <= out_p_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Directed bench for booth_r4_seq_mult: DPC=1 instance for latency/handshake/reset cases,
// DPC=3 instance for product and latency over mixed signed/unsigned operand pairs.
module tb_booth_r4_seq_mult;

  logic        clk;
  logic        rst;

  logic        in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [15:0] in_a, in_b;
  logic [31:0] out_p;

  logic        in_valid3, in_ready3, in_signed3, out_valid3, out_ready3;
  logic [15:0] in_a3, in_b3;
  logic [31:0] out_p3;

  int checks = 0;
  int errors = 0;

  booth_r4_seq_mult #(.WIDTH(16), .DPC(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p)
  );

  booth_r4_seq_mult #(.WIDTH(16), .DPC(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_signed(in_signed3),
    .in_a(in_a3), .in_b(in_b3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_p(out_p3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op on the DPC=1 instance and wait for its product (no handshake yet)
  task automatic start_wait1(input logic sgn, input logic [15:0] a, input logic [15:0] b,
                             output int lat);
    @(negedge clk);
    check("in_ready_before_accept", in_ready, 1'b1);
    in_valid = 1'b1; in_signed = sgn; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake1;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_after_hs", out_valid, 1'b0);
    check("in_ready_after_hs", in_ready, 1'b1);
  endtask

  task automatic op1(input string tag, input logic sgn, input logic [15:0] a,
                     input logic [15:0] b, input logic [31:0] exp_p, input int exp_lat);
    int lat;
    start_wait1(sgn, a, b, lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_p"}, 64'(out_p), 64'(exp_p));
    handshake1();
  endtask

  task automatic op3(input string tag, input logic sgn, input logic [15:0] a,
                     input logic [15:0] b);
    int lat;
    longint sa, sb, prod;
    logic [31:0] exp_p;
    sa = sgn ? longint'($signed(a)) : longint'({1'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({1'b0, b});
    prod  = sa * sb;
    exp_p = prod[31:0];
    @(negedge clk);
    in_valid3 = 1'b1; in_signed3 = sgn; in_a3 = a; in_b3 = b;
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    lat = 0;
    while (!out_valid3 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd3);
    check({tag, "_p"}, 64'(out_p3), 64'(exp_p));
    @(negedge clk);
    out_ready3 = 1'b1;
    @(posedge clk); #1;
    out_ready3 = 1'b0;
  endtask

  logic [31:0] held_p;
  int          lat;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_signed = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    in_valid3 = 1'b0; in_signed3 = 1'b0; in_a3 = '0; in_b3 = '0; out_ready3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_p", out_p, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    op1("s_min_min", 1'b1, 16'h8000, 16'h8000, 32'h4000_0000, 8);
    op1("u_ffff_ffff", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 9);
    op1("s_ffff_ffff", 1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001, 8);
    op1("s_m1_x1", 1'b1, 16'hFFFF, 16'h0001, 32'hFFFF_FFFF, 8);
    op1("s_max_min", 1'b1, 16'h7FFF, 16'h8000, 32'hC000_8000, 8);
    op1("s_zero", 1'b1, 16'h0000, 16'h1234, 32'h0000_0000, 8);
    op1("u_mixed", 1'b0, 16'h8001, 16'h00FF, 32'h007F_80FF, 9);
    op1("s_mixed", 1'b1, 16'h1234, 16'hFF00, 32'hFFED_CC00, 8);

    // Backpressure: product held while out_ready is low; new operands ignored
    start_wait1(1'b1, 16'd300, 16'hFFF6, lat);
    check("bp_lat", 64'(lat), 64'd8);
    check("bp_p", out_p, 32'hFFFF_F448);
    held_p = out_p;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_signed = 1'b0; in_a = 16'h0101; in_b = 16'h0202;
      @(posedge clk); #1;
      check("bp_hold_p", out_p, held_p);
      check("bp_hold_vld", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    handshake1();
    repeat (3) begin
      @(posedge clk); #1;
      check("post_hs_idle", out_valid, 1'b0);
      check("post_hs_keep_p", out_p, held_p);
    end

    // Abort mid-RUN with reset
    @(negedge clk);
    in_valid = 1'b1; in_signed = 1'b1; in_a = 16'h00AA; in_b = 16'h0055;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_p", out_p, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      check("abort_no_output", out_valid, 1'b0);
    end
    op1("s_3x5", 1'b1, 16'd3, 16'd5, 32'd15, 8);

    // DPC=3 instance: corners then a mixed pseudo-random set
    op3("d3_s_min_min", 1'b1, 16'h8000, 16'h8000);
    op3("d3_u_ffff", 1'b0, 16'hFFFF, 16'hFFFF);
    op3("d3_s_ffff", 1'b1, 16'hFFFF, 16'hFFFF);
    op3("d3_s_max_min", 1'b1, 16'h7FFF, 16'h8000);
    op3("d3_zero", 1'b0, 16'h0000, 16'hBEEF);
    for (int n = 0; n < 300; n++) begin
      op3("d3_rand", 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
